reg_bank: RTL and testbench

Parametrised successor to the 4-entry CPU register file. It provides a DEPTH x W register bank with two combinational read ports, a dedicated register-0 tap, and one clocked write port. New in this generation: asynchronous reset, per-entry valid bits, and a sequential clear-sweep engine with a busy flag. It sits between the decode stage (read addresses) and the writeback mux (write data) of the custom CPU datapath.

---
 rtl/reg_bank_if.sv | 29 ++
 rtl/reg_bank.sv | 115 +++++++++++
 tb/tb_reg_bank.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_if.sv
// reg_bank_if: bus bundle between the CPU datapath (master) and reg_bank (slave).
// Carries the write port, both read ports, the register-0 tap and the clear-sweep handshake.
interface reg_bank_if #(
  parameter int W  = 8,
  parameter int PW = 4
);
  logic [W-1:0]  dat_in;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] rd_addrA;
  logic [PW-1:0] rd_addrB;
  logic          clr_req;
  logic [W-1:0]  datA_out;
  logic [W-1:0]  datB_out;
  logic [W-1:0]  dat0_out;
  logic          vldA;
  logic          vldB;
  logic          busy;

  modport master (
    output dat_in, wr_en, wr_addr, rd_addrA, rd_addrB, clr_req,
    input  datA_out, datB_out, dat0_out, vldA, vldB, busy
  );

  modport slave (
    input  dat_in, wr_en, wr_addr, rd_addrA, rd_addrB, clr_req,
    output datA_out, datB_out, dat0_out, vldA, vldB, busy
  );
endinterface

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x W register bank, two combinational read ports, register-0 tap,
// one clocked write port, per-entry valid bits and a sequential clear sweep.
// Optional build macro REG_BANK_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_bank #(
  parameter int W  = 8,
  parameter int PW = 4
) (
  input logic       clk,
  input logic       rst_n,
  reg_bank_if.slave bus
);
  localparam int DEPTH = 2 ** PW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  core_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic          busy;
  logic          wr_fire;
  logic [W-1:0]  rd_a, rd_b, rd_0;
  logic          v_a, v_b;

  assign busy    = (state_q == ST_SWEEP);
  // Writes are dropped during a sweep; reset gating keeps outputs at zero while held in reset.
  assign wr_fire = bus.wr_en && !busy && rst_n;

  // Next-state logic for the clear-sweep FSM and its pointer.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (&ptr_q) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // FSM state and sweep pointer registers.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage: sweep clears one entry per cycle, otherwise the write port updates an entry.
  // NOTE: the storage array is reset on purpose -- reset must clear every entry immediately,
  // so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) core_q[i] <= '0;
      vld_q <= '0;
    end else if (busy) begin
      core_q[ptr_q] <= '0;
      vld_q[ptr_q]  <= 1'b0;
    end else if (wr_fire) begin
      core_q[bus.wr_addr] <= bus.dat_in;
      vld_q[bus.wr_addr]  <= 1'b1;
    end
  end

  // Combinational read ports, with optional same-cycle write forwarding.
  always_comb begin
    rd_a = core_q[bus.rd_addrA];
    rd_b = core_q[bus.rd_addrB];
    rd_0 = core_q[0];
    v_a  = vld_q[bus.rd_addrA];
    v_b  = vld_q[bus.rd_addrB];
`ifdef REG_BANK_BYPASS_EN
    if (wr_fire) begin
      if (bus.rd_addrA == bus.wr_addr) begin
        rd_a = bus.dat_in;
        v_a  = 1'b1;
      end
      if (bus.rd_addrB == bus.wr_addr) begin
        rd_b = bus.dat_in;
        v_b  = 1'b1;
      end
      if (bus.wr_addr == '0) rd_0 = bus.dat_in;
    end
`else
    // Without forwarding, a read of the entry being written returns its pre-write value.
`endif
  end

  assign bus.datA_out = rd_a;
  assign bus.datB_out = rd_b;
  assign bus.dat0_out = rd_0;
  assign bus.vldA     = v_a;
  assign bus.vldB     = v_b;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: self-checking bench for reg_bank against an array-based reference model.
module tb_reg_bank;
  localparam int W     = 8;
  localparam int PW    = 4;
  localparam int DEPTH = 2 ** PW;

  logic clk;
  logic rst_n;

  reg_bank_if #(.W(W), .PW(PW)) bus ();

  reg_bank #(.W(W), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents, valid bits, and sweep progress counted in edges.
  logic [W-1:0] m_core [DEPTH];
  logic         m_vld  [DEPTH];
  bit           m_busy;
  int           m_idx;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_core[i] = '0;
      m_vld[i]  = 1'b0;
    end
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  // One clock edge: the model consumes the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (m_busy) begin
      m_core[m_idx] = '0;
      m_vld[m_idx]  = 1'b0;
      m_idx++;
      if (m_idx == DEPTH) m_busy = 1'b0;
    end else begin
      if (bus.wr_en) begin
        m_core[bus.wr_addr] = bus.dat_in;
        m_vld[bus.wr_addr]  = 1'b1;
      end
      if (bus.clr_req) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
    end
    #1;
  endtask

  // Compare every output against the model for the current input values.
  task automatic check_reads();
    logic [W-1:0] ea, eb, e0;
    logic         va, vb;
    ea = m_core[bus.rd_addrA];
    eb = m_core[bus.rd_addrB];
    e0 = m_core[0];
    va = m_vld[bus.rd_addrA];
    vb = m_vld[bus.rd_addrB];
`ifdef REG_BANK_BYPASS_EN
    if (bus.wr_en && !m_busy && rst_n) begin
      if (bus.rd_addrA == bus.wr_addr) begin ea = bus.dat_in; va = 1'b1; end
      if (bus.rd_addrB == bus.wr_addr) begin eb = bus.dat_in; vb = 1'b1; end
      if (bus.wr_addr == '0) e0 = bus.dat_in;
    end
`endif
    check("datA", 32'(bus.datA_out), 32'(ea));
    check("datB", 32'(bus.datB_out), 32'(eb));
    check("dat0", 32'(bus.dat0_out), 32'(e0));
    check("vldA", 32'(bus.vldA), 32'(va));
    check("vldB", 32'(bus.vldB), 32'(vb));
    check("busy", 32'(bus.busy), 32'(m_busy));
  endtask

  // Walk every address on both read ports; inputs that could change state are held low.
  task automatic scan();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addrA = PW'(i);
      bus.rd_addrB = PW'(DEPTH - 1 - i);
      #1;
      check_reads();
    end
  endtask

  task automatic write(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = PW'(addr);
    bus.dat_in  = W'(data);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Follows a sweep that started at the last edge. Optionally pulses clr_req again,
  // attempts a write to entry 2, or asserts reset at a given sweep cycle.
  task automatic run_sweep(input int repulse_at, input int write_at, input int reset_at);
    int busy_cnt = 0;
    bit done = 1'b0;
    for (int c = 0; c < DEPTH + 8; c++) begin
      bus.wr_en    = 1'b0;
      bus.clr_req  = 1'b0;
      bus.rd_addrA = PW'($urandom);
      bus.rd_addrB = PW'($urandom);
      if (c == write_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = PW'(2);
        bus.dat_in  = 8'h55;
      end
      if (c == repulse_at) bus.clr_req = 1'b1;
      #1;
      check_reads();
      if (c == reset_at) begin
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        scan();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      busy_cnt++;
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b0;
    if (!done) check("sweep_timeout", 32'd1, 32'd0);
    check("busy_len", 32'(busy_cnt), 32'(DEPTH));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.dat_in   = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.rd_addrA = '0;
    bus.rd_addrB = '0;
    bus.clr_req  = 1'b0;
    m_reset();
    #2;
    scan();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read, plus an unwritten entry.
    write(3, 8'hA5);
    write(0, 8'h3C);
    bus.rd_addrA = 4'd3;
    bus.rd_addrB = 4'd0;
    #1;
    check_reads();
    bus.rd_addrA = 4'd7;
    #1;
    check_reads();

    // Same-cycle read of the address being written.
    write(5, 8'h11);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 4'd5;
    bus.dat_in   = 8'h77;
    bus.rd_addrA = 4'd5;
    #1;
    check_reads();
    tick();
    bus.wr_en = 1'b0;
    #1;
    check_reads();

    // Full sweep over an all-0xFF bank; a write to entry 2 is attempted mid-sweep.
    for (int i = 0; i < DEPTH; i++) write(i, 8'hFF);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    run_sweep(-1, 3, -1);
    scan();
    write(2, 8'h55);
    bus.rd_addrA = 4'd2;
    #1;
    check_reads();

    // clr_req pulsed again during a sweep must not extend it.
    for (int i = 0; i < DEPTH; i++) write(i, 8'hFF);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    run_sweep(5, -1, -1);
    scan();

    // Reset asserted at sweep cycle 4 aborts the sweep.
    for (int i = 0; i < DEPTH; i++) write(i, 8'hFF);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    run_sweep(-1, -1, 4);

    // Write and clr_req in the same cycle: the sweep later clears that entry.
    write(4, 8'h44);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 4'd9;
    bus.dat_in   = 8'h99;
    bus.clr_req  = 1'b1;
    bus.rd_addrA = 4'd9;
    #1;
    check_reads();
    tick();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b0;
    run_sweep(-1, -1, -1);
    scan();

    // Randomized traffic with occasional clear requests.
    for (int n = 0; n < 300; n++) begin
      bus.wr_en    = 1'($urandom);
      bus.wr_addr  = PW'($urandom);
      bus.dat_in   = W'($urandom);
      bus.rd_addrA = ($urandom_range(0, 3) == 0) ? bus.wr_addr : PW'($urandom);
      bus.rd_addrB = PW'($urandom);
      bus.clr_req  = ($urandom_range(0, 29) == 0);
      #1;
      check_reads();
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b0;

    // Asynchronous reset mid-cycle with no clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    scan();
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
